// File: rtl/calc_if.sv
// rtl/calc_if.sv - keypad/display/result bundle between a keypad driver and calc_core
//
// Purpose: groups the key input handshake and all calculator outputs.
// Signals:
//   key_valid    one-cycle key strobe
//   key_code     4-bit key (0-9 digit, a + b - c * d / e = f C)
//   seg_data     eight 5-bit display codes, [4:0] rightmost
//   seg_data_en  digit enables
//   seg_dot_en   decimal-point enables
//   busy         computation in progress
//   result       magnitude of the last result (RW bits)
//   result_neg   sign of the last result
// Modports: master drives keys and observes outputs, slave is the calculator.
interface calc_if #(
    parameter int DIG = 2
);
    localparam int OW = $clog2(10**DIG);
    localparam int RW = 2 * OW;

    logic          key_valid;
    logic [3:0]    key_code;
    logic [39:0]   seg_data;
    logic [7:0]    seg_data_en;
    logic [7:0]    seg_dot_en;
    logic          busy;
    logic [RW-1:0] result;
    logic          result_neg;

    modport master (
        output key_valid, key_code,
        input  seg_data, seg_data_en, seg_dot_en, busy, result, result_neg
    );

    modport slave (
        input  key_valid, key_code,
        output seg_data, seg_data_en, seg_dot_en, busy, result, result_neg
    );
endinterface

// File: rtl/calc_core.sv
// rtl/calc_core.sv - keypad calculator core with sequential mul/div and BCD display conversion
//
// Purpose: accepts two decimal operands and an operator from a keypad, computes
// +, -, * (shift-add), / (restoring) and converts the result to BCD (double dabble)
// for an eight-digit display.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  calc_if slave: key_valid/key_code in; seg_data, seg_data_en, seg_dot_en,
//        busy, result, result_neg out
module calc_core #(
    parameter int DIG = 2
) (
    input  logic  clk,
    input  logic  rst,
    calc_if.slave bus
);
    localparam int OW = $clog2(10**DIG);
    localparam int RW = 2 * OW;
    localparam int CW = $clog2(RW + 1);
    localparam int BW = 4 * DIG;
    localparam logic [RW-1:0] MAXV = RW'(10**DIG - 1);

    localparam logic [3:0] K_ADD = 4'ha, K_SUB = 4'hb, K_MUL = 4'hc, K_DIV = 4'hd;
    localparam logic [3:0] K_EQ  = 4'he, K_CLR = 4'hf;
    localparam logic [4:0] C_MINUS = 5'd12, C_E = 5'd15, C_BLANK = 5'd16, C_R = 5'd17;

    typedef enum logic [2:0] {IDLE, A_ENT, OP, B_ENT, CALC, CONV, SHOW, ERR} state_t;

    state_t        state;
    logic [OW-1:0] a, b;
    logic [BW-1:0] a_bcd, b_bcd;   // decimal copies of the operands, for display
    logic [3:0]    op;
    logic [2:0]    count;
    logic [RW-1:0] acc, mcand;
    logic [OW-1:0] mplier, quo, rem;
    logic [CW-1:0] cyc;
    logic [RW-1:0] bin;
    logic [31:0]   bcd;
    logic [39:0]   seg_data;
    logic          busy;
    logic [RW-1:0] result;
    logic          result_neg;

    assign bus.seg_data    = seg_data;
    assign bus.seg_data_en = 8'hFF;
    assign bus.seg_dot_en  = 8'h00;
    assign bus.busy        = busy;
    assign bus.result      = result;
    assign bus.result_neg  = result_neg;

    logic          key_digit, key_op, key_clr;
    logic [OW-1:0] d_ow;
    logic [BW-1:0] d_bcd;

    assign key_digit = bus.key_valid && (bus.key_code <= 4'd9);
    assign key_op    = bus.key_valid && (bus.key_code >= K_ADD) && (bus.key_code <= K_DIV);
    assign key_clr   = bus.key_valid && (bus.key_code == K_CLR);
    assign d_ow      = OW'(bus.key_code);
    assign d_bcd     = BW'(bus.key_code);

    // One step of each sequential algorithm plus the value to commit on CALC exit.
    logic [RW-1:0] acc_nx, calc_val;
    logic [OW:0]   rem_sh;
    logic [OW-1:0] rem_nx, quo_nx;
    logic          calc_neg, calc_last;

    always_comb begin
        acc_nx = acc + (mplier[0] ? mcand : '0);
        rem_sh = {rem, quo[OW-1]};
        if (rem_sh >= {1'b0, b}) begin
            rem_nx = OW'(rem_sh - {1'b0, b});
            quo_nx = {quo[OW-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[OW-1:0];
            quo_nx = {quo[OW-2:0], 1'b0};
        end
        calc_val = acc_nx;
        calc_neg = 1'b0;
        case (op)
            K_ADD: calc_val = RW'(a) + RW'(b);
            K_SUB: begin
                calc_neg = (a < b);
                calc_val = (a < b) ? RW'(b) - RW'(a) : RW'(a) - RW'(b);
            end
            K_DIV: calc_val = RW'(quo_nx);
            default: ;
        endcase
        calc_last = (op == K_ADD) || (op == K_SUB) || (cyc == CW'(OW - 1));
    end

    // Double dabble: add 3 to every BCD nibble >= 5 before each shift.
    logic [31:0] bcd_adj;
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 8; i++)
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    logic [39:0] disp_next;
    int          msd;
    always_comb begin
        disp_next = {8{C_BLANK}};
        msd       = 0;
        case (state)
            A_ENT, OP: begin
                for (int i = 0; i < DIG; i++)
                    if (i < int'(count)) disp_next[5*i +: 5] = {1'b0, a_bcd[4*i +: 4]};
                if (state == OP) disp_next[39:35] = {1'b0, op};
            end
            B_ENT: begin
                for (int i = 0; i < DIG; i++)
                    if (i < int'(count)) disp_next[5*i +: 5] = {1'b0, b_bcd[4*i +: 4]};
            end
            CALC, CONV: disp_next = seg_data;
            SHOW: begin
                for (int i = 0; i < 8; i++)
                    if (bcd[4*i +: 4] != 4'd0) msd = i;
                for (int i = 0; i < 8; i++)
                    if (i <= msd) disp_next[5*i +: 5] = {1'b0, bcd[4*i +: 4]};
                if (result_neg && msd < 7) disp_next[5*(msd+1) +: 5] = C_MINUS;
            end
            ERR: disp_next[14:0] = {C_E, C_R, C_R};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;   a <= '0;      b <= '0;     a_bcd <= '0;  b_bcd <= '0;
            op <= '0;        count <= '0;  acc <= '0;   mcand <= '0;  mplier <= '0;
            quo <= '0;       rem <= '0;    cyc <= '0;   bin <= '0;    bcd <= '0;
            seg_data <= {8{C_BLANK}};      busy <= 1'b0;
            result <= '0;    result_neg <= 1'b0;
        end else begin
            seg_data <= disp_next;
            if (key_clr) begin
                // Clear wins in every state, aborting any computation in flight.
                state <= IDLE;   a <= '0;      b <= '0;     a_bcd <= '0;  b_bcd <= '0;
                op <= '0;        count <= '0;  bcd <= '0;   busy <= 1'b0;
                result <= '0;    result_neg <= 1'b0;
            end else begin
                case (state)
                    IDLE, SHOW: begin
                        if (key_digit) begin
                            a <= d_ow;  a_bcd <= d_bcd;  count <= 3'd1;  state <= A_ENT;
                        end else if (state == SHOW && key_op && !result_neg && result <= MAXV) begin
                            // Chain: the shown result becomes operand A.
                            a <= result[OW-1:0];  a_bcd <= bcd[BW-1:0];
                            count <= 3'(DIG);     op <= bus.key_code;  state <= OP;
                        end
                    end
                    A_ENT: begin
                        if (key_digit && count < 3'(DIG)) begin
                            a <= a * OW'(10) + d_ow;  a_bcd <= (a_bcd << 4) | d_bcd;
                            count <= count + 3'd1;
                        end else if (key_op) begin
                            op <= bus.key_code;  state <= OP;
                        end
                    end
                    OP: begin
                        if (key_digit) begin
                            b <= d_ow;  b_bcd <= d_bcd;  count <= 3'd1;  state <= B_ENT;
                        end else if (key_op) begin
                            op <= bus.key_code;
                        end
                    end
                    B_ENT: begin
                        if (key_digit && count < 3'd0 + 3'(DIG)) begin
                            b <= b * OW'(10) + d_ow;  b_bcd <= (b_bcd << 4) | d_bcd;
                            count <= count + 3'd1;
                        end else if (bus.key_valid && bus.key_code == K_EQ) begin
                            acc <= '0;  mcand <= RW'(a);  mplier <= b;
                            quo <= a;   rem <= '0;        cyc <= '0;
                            busy <= 1'b1;  state <= CALC;
                        end
                    end
                    CALC: begin
                        if (op == K_DIV && b == '0) begin
                            busy <= 1'b0;  state <= ERR;
                        end else begin
                            acc <= acc_nx;   mcand <= mcand << 1;  mplier <= mplier >> 1;
                            quo <= quo_nx;   rem <= rem_nx;        cyc <= cyc + 1'b1;
                            if (calc_last) begin
                                result <= calc_val;  result_neg <= calc_neg;
                                bin <= calc_val;     bcd <= '0;
                                cyc <= '0;           state <= CONV;
                            end
                        end
                    end
                    CONV: begin
                        {bcd, bin} <= {bcd_adj, bin} << 1;
                        cyc <= cyc + 1'b1;
                        if (cyc == CW'(RW - 1)) begin
                            busy <= 1'b0;  state <= SHOW;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_calc_core.sv
// tb/tb_calc_core.sv - directed self-checking bench for calc_core (DIG=2 and DIG=4 instances)
module tb_calc_core;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    calc_if #(.DIG(2)) if2 ();
    calc_if #(.DIG(4)) if4 ();

    calc_core #(.DIG(2)) u2 (.clk(clk), .rst(rst), .bus(if2));
    calc_core #(.DIG(4)) u4 (.clk(clk), .rst(rst), .bus(if4));

    int checks = 0;
    int passes = 0;
    int n;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // s[0] is the leftmost display digit.
    function automatic logic [39:0] d8(input string s);
        logic [39:0] r;
        logic [4:0]  c;
        byte         ch;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            ch = s[i];
            case (ch)
                " ": c = 5'd16;
                "+": c = 5'd10;
                "-": c = 5'd12;
                "*": c = 5'd12;
                "/": c = 5'd13;
                "E": c = 5'd15;
                "r": c = 5'd17;
                default: c = 5'(ch - "0");
            endcase
            r[5*(7-i) +: 5] = c;
        end
        return r;
    endfunction

    task automatic press2(input logic [3:0] k);
        @(negedge clk);
        if2.key_valid = 1'b1;
        if2.key_code  = k;
        @(negedge clk);
        if2.key_valid = 1'b0;
    endtask

    task automatic press4(input logic [3:0] k);
        @(negedge clk);
        if4.key_valid = 1'b1;
        if4.key_code  = k;
        @(negedge clk);
        if4.key_valid = 1'b0;
    endtask

    task automatic wait2(output int cnt);
        cnt = 0;
        while (if2.busy && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic wait4(output int cnt);
        cnt = 0;
        while (if4.busy && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        rst = 1'b1;
        if2.key_valid = 1'b0;  if2.key_code = 4'h0;
        if4.key_valid = 1'b0;  if4.key_code = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_seg", if2.seg_data, d8("        "));
        chk("rst_en", if2.seg_data_en, 8'hFF);
        chk("rst_dot", if2.seg_dot_en, 8'h00);
        chk("rst_busy", if2.busy, 1'b0);
        chk("rst_result", if2.result, 14'd0);
        chk("rst_neg", if2.result_neg, 1'b0);
        chk("rst_seg4", if4.seg_data, d8("        "));
        rst = 1'b0;

        // 12 + 34
        press2(4'd1); press2(4'd2); @(negedge clk);
        chk("entry_a", if2.seg_data, d8("      12"));
        press2(4'ha); @(negedge clk);
        chk("op_disp", if2.seg_data, d8("+     12"));
        press2(4'd3); press2(4'd4); press2(4'he);
        wait2(n);
        chk("add_busy_cycles", n, 15);
        @(negedge clk);
        chk("add_disp", if2.seg_data, d8("      46"));
        chk("add_result", if2.result, 14'd46);
        chk("add_neg", if2.result_neg, 1'b0);

        press2(4'hf); @(negedge clk);
        chk("clr_disp", if2.seg_data, d8("        "));
        chk("clr_result", if2.result, 14'd0);

        // 05 - 12 with an entered leading zero
        press2(4'd0); press2(4'd5); @(negedge clk);
        chk("lead_zero", if2.seg_data, d8("      05"));
        press2(4'hb); press2(4'd1); press2(4'd2); press2(4'he);
        wait2(n);
        chk("sub_busy_cycles", n, 15);
        @(negedge clk);
        chk("sub_disp", if2.seg_data, d8("      -7"));
        chk("sub_result", if2.result, 14'd7);
        chk("sub_neg", if2.result_neg, 1'b1);
        press2(4'ha); @(negedge clk);
        chk("neg_chain_ignored", if2.seg_data, d8("      -7"));

        // 5 - 5 shows a single zero
        press2(4'hf); press2(4'd5); press2(4'hb); press2(4'd5); press2(4'he);
        wait2(n); @(negedge clk);
        chk("zero_disp", if2.seg_data, d8("       0"));
        chk("zero_neg", if2.result_neg, 1'b0);

        // 99 * 99, third digit ignored
        press2(4'hf); press2(4'd9); press2(4'd9); press2(4'd9); @(negedge clk);
        chk("digit_limit", if2.seg_data, d8("      99"));
        press2(4'hc); press2(4'd9); press2(4'd9); press2(4'he);
        wait2(n);
        chk("mul_busy_cycles", n, 21);
        @(negedge clk);
        chk("mul_disp", if2.seg_data, d8("    9801"));
        chk("mul_result", if2.result, 14'd9801);
        press2(4'd9); @(negedge clk);
        chk("new_entry", if2.seg_data, d8("       9"));

        // 7 / 0
        press2(4'hf); press2(4'd7); press2(4'hd); press2(4'd0); press2(4'he);
        wait2(n);
        chk("div0_busy_cycles", n, 1);
        @(negedge clk);
        chk("err_disp", if2.seg_data, d8("     Err"));
        press2(4'd5); @(negedge clk);
        chk("err_digit_ignored", if2.seg_data, d8("     Err"));
        press2(4'hf); @(negedge clk);
        chk("err_clear", if2.seg_data, d8("        "));
        chk("err_clear_busy", if2.busy, 1'b0);

        // 6 * 7 then + 3, with keys during busy dropped
        press2(4'd6); press2(4'hc); press2(4'd7); press2(4'he);
        wait2(n); @(negedge clk);
        chk("chain_first", if2.seg_data, d8("      42"));
        press2(4'ha); @(negedge clk);
        chk("chain_op", if2.seg_data, d8("+     42"));
        press2(4'd3); press2(4'he);
        press2(4'd8); press2(4'hc);
        wait2(n); @(negedge clk);
        chk("chain_disp", if2.seg_data, d8("      45"));
        chk("chain_result", if2.result, 14'd45);

        // DIG=4: 8 / 3, then abort a second division two cycles into CALC
        press4(4'd8); press4(4'hd); press4(4'd3); press4(4'he);
        wait4(n);
        chk("div4_busy_cycles", n, 42);
        @(negedge clk);
        chk("div4_disp", if4.seg_data, d8("       2"));
        chk("div4_result", if4.result, 28'd2);
        press4(4'd8); press4(4'hd); press4(4'd3); press4(4'he);
        @(negedge clk);
        press4(4'hf);
        chk("abort_busy", if4.busy, 1'b0);
        chk("abort_result", if4.result, 28'd0);
        @(negedge clk);
        chk("abort_disp", if4.seg_data, d8("        "));
        repeat (40) @(negedge clk);
        chk("abort_no_update", if4.result, 28'd0);
        chk("abort_stays_idle", if4.busy, 1'b0);
        chk("abort_disp_held", if4.seg_data, d8("        "));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/calc_core.md
CALC_CORE -- requirements
Module: calc_core

Interface
REQ-001 SHALL have parameter DIG, default 2, range 1..4: maximum decimal digits per operand.
REQ-002 SHALL have localparam OW = ceil(log2(10^DIG)) (operand width) and RW = 2*OW (result width).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 key_valid  input  1  one-cycle pulse; key_code is valid in that cycle.
REQ-006 key_code  input  4  0-9 digit, a '+', b '-', c '*', d '/', e '=', f 'C'.
REQ-007 seg_data  output  40  eight 5-bit display codes; bits [4:0] are the rightmost digit, bits [39:35] the leftmost.
REQ-008 seg_data_en  output  8  digit enables.
REQ-009 seg_dot_en  output  8  decimal-point enables.
REQ-010 busy  output  1  high while a computation is in progress.
REQ-011 result  output  RW  magnitude of the last result.
REQ-012 result_neg  output  1  sign of the last result.

Function
REQ-013 Display codes SHALL be: 0-9 digit, 10-13 operator symbol (same value as key_code), 12 also minus sign, 15 'E', 16 blank, 17 'r'.
REQ-014 FSM states SHALL be IDLE, A_ENT, OP, B_ENT, CALC, CONV, SHOW, ERR.
REQ-015 A key SHALL be accepted only on an edge where key_valid=1; the state transition happens on that same edge.
REQ-016 'C' SHALL go to IDLE from any state, including CALC/CONV, and SHALL abort any computation; A, B, op, result and result_neg clear to 0.
REQ-017 IDLE + digit d -> A_ENT, with A=d and digit count=1.
REQ-018 A_ENT + digit: if count<DIG then A=A*10+d and count++; otherwise the digit is ignored.
REQ-019 A_ENT + operator -> OP, and op is stored.
REQ-020 OP + digit -> B_ENT with B=d; OP + operator replaces op.
REQ-021 B_ENT + digit follows the same rule as REQ-018 applied to B; B_ENT + '=' -> CALC.
REQ-022 '=' in IDLE/A_ENT/OP, and operators in B_ENT, SHALL be ignored.
REQ-023 CALC, '+': 1 cycle; result = A+B.
REQ-024 CALC, '-': 1 cycle; if A>=B then result=A-B, neg=0; else result=B-A, neg=1.
REQ-025 CALC, '*': sequential shift-add, exactly OW cycles.
REQ-026 CALC, '/': restoring division, exactly OW cycles; quotient is truncated; remainder is discarded.
REQ-027 '/' with B=0 SHALL go from CALC to ERR after 1 cycle, without dividing.
REQ-028 CONV: sequential double-dabble binary-to-BCD, exactly RW cycles, then -> SHOW.
REQ-029 busy SHALL be 1 in CALC and CONV, and 0 otherwise.
REQ-030 Only 'C' is accepted while busy=1; all other keys are dropped, not queued.
REQ-031 result and result_neg SHALL update on the edge leaving CALC and hold until the next CALC exit or clear.
REQ-032 SHOW + digit SHALL behave as IDLE + digit.
REQ-033 SHOW + operator: if neg=0 and result<=10^DIG-1, then A=result, count=DIG, -> OP; otherwise ignored.
REQ-034 ERR SHALL accept only 'C'.
REQ-035 Display during A_ENT/B_ENT: the operand being entered, right-aligned, leading positions blank, showing exactly count digits (so entered leading zeros are shown).
REQ-036 Display during OP: A right-aligned, operator code on the leftmost digit.
REQ-037 Display during CALC/CONV: the previous contents are held.
REQ-038 Display during SHOW: result right-aligned with leading zeros blanked (a zero result shows a single '0'); if neg=1, code 12 sits immediately left of the most significant digit.
REQ-039 Display during ERR: rightmost three digits 'E','r','r'; all others blank.
REQ-040 seg_data SHALL be registered and reflect the new state one cycle after the transition.
REQ-041 seg_data_en SHALL be constant 8'hFF; seg_dot_en SHALL be constant 8'h00.

Reset
REQ-042 On rst: state=IDLE; A, B, op, count, result, result_neg = 0; busy=0; all eight seg_data digits = 16; seg_data_en=8'hFF; seg_dot_en=8'h00.
REQ-043 Reset asserted mid-CALC/CONV SHALL abort the computation, with no later result update.

Verification
REQ-044 DIG=2; keys 1,2,+,3,4,= -> busy high for 1+RW cycles, then display "      46", result=46, neg=0.
REQ-045 DIG=2; keys 5,-,1,2,= -> display "      -7", result=7, result_neg=1.
REQ-046 DIG=2; keys 9,9,*,9,9,=,9 -> third '9' ignored; busy for OW+RW cycles; display "    9801"; then the final 9 starts a new entry, display "       9".
REQ-047 DIG=2; keys 7,/,0,= -> ERR, display "     Err"; a digit key has no effect; 'C' -> all blank, IDLE.
REQ-048 DIG=4; keys 8,/,3,= then 'C' asserted two cycles into CALC -> busy drops next cycle, display blank, result=0.
REQ-049 DIG=2; keys 6,*,7,=,+,3,= (chaining) -> display "      45"; key_valid asserted during busy (non-'C') has no effect.
